// File: rtl/nrd_result_fifo_if.sv
// Handshake bundle for the non-restoring divider result stage.
// The slave modport is the FIFO's view; the master modport is the producer/consumer view.
interface nrd_result_fifo_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_Q;
   logic [WIDTH:0]   in_A;
   logic [WIDTH-1:0] in_D1;
   logic [WIDTH-1:0] in_D2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_Q;
   logic [WIDTH-1:0] out_R;
   logic             out_dbz;
   logic [CW-1:0]    count;

   modport slave (
      input  in_valid, in_Q, in_A, in_D1, in_D2, out_ready,
      output in_ready, out_valid, out_Q, out_R, out_dbz, count
   );

   modport master (
      output in_valid, in_Q, in_A, in_D1, in_D2, out_ready,
      input  in_ready, out_valid, out_Q, out_R, out_dbz, count
   );
endinterface

// File: rtl/nrd_result_fifo.sv
// Result stage of the non-restoring divider: corrects the final partial
// remainder at push time and buffers corrected results in a DEPTH-entry FIFO.
// Optional build macro NRD_DBZ_DETECT_EN: flag divisor==0 pushes and store
// Q=all-ones, R=dividend, dbz=1 for them. Without it out_dbz is tied low.
module nrd_result_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   nrd_result_fifo_if.slave    bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Occupancy states; the state is fully determined by r_count.
   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_PARTIAL = 2'd1;
   localparam logic [1:0] ST_FULL    = 2'd2;

   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_q_mem [DEPTH];
   logic [WIDTH-1:0] r_r_mem [DEPTH];

   logic [1:0]       w_state;
   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_push;
   logic             w_pop;
   logic [WIDTH:0]   w_a_plus_d2;
   logic [WIDTH-1:0] w_q_corr;
   logic [WIDTH-1:0] w_r_corr;

   // Decode occupancy state from the counter.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_state = ST_PARTIAL;
      if (r_count == '0)
         w_state = ST_EMPTY;
      else if (r_count == CW'(DEPTH))
         w_state = ST_FULL;
   end

   // Full blocks input even when a pop happens in the same cycle (no fall-through).
   assign w_in_ready  = (w_state != ST_FULL) & ~rst;
   assign w_out_valid = (w_state != ST_EMPTY);
   assign w_push      = bus.in_valid & w_in_ready;
   assign w_pop       = w_out_valid & bus.out_ready;

   // A negative final remainder is fixed by adding the divisor back once.
   assign w_a_plus_d2 = bus.in_A + {1'b0, bus.in_D2};

`ifdef NRD_DBZ_DETECT_EN
   logic r_dbz_mem [DEPTH];
   logic w_dbz_corr;

   // Remainder correction with divide-by-zero override.
   always_comb begin
      w_q_corr   = bus.in_Q;
      w_r_corr   = bus.in_A[WIDTH] ? w_a_plus_d2[WIDTH-1:0] : bus.in_A[WIDTH-1:0];
      w_dbz_corr = 1'b0;
      if (bus.in_D2 == '0) begin
         w_q_corr   = '1;
         w_r_corr   = bus.in_D1;
         w_dbz_corr = 1'b1;
      end
   end

   // Divide-by-zero flag storage, written alongside the data entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            r_dbz_mem[i] <= 1'b0;
      end else if (w_push) begin
         r_dbz_mem[r_wr_ptr] <= w_dbz_corr;
      end
   end

   assign bus.out_dbz = r_dbz_mem[r_rd_ptr];
`else
   logic w_unused_d1;

   // Remainder correction; a zero divisor takes the normal path.
   always_comb begin
      w_q_corr = bus.in_Q;
      w_r_corr = bus.in_A[WIDTH] ? w_a_plus_d2[WIDTH-1:0] : bus.in_A[WIDTH-1:0];
   end

   // The dividend only matters for divide-by-zero reporting.
   assign w_unused_d1 = ^bus.in_D1;
   assign bus.out_dbz = 1'b0;
`endif

   // Data storage, cleared on reset so no stale entry is ever visible.
   // NOTE: the storage is reset on purpose: outputs read straight from it must show zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_q_mem[i] <= '0;
            r_r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_q_mem[r_wr_ptr] <= w_q_corr;
         r_r_mem[r_wr_ptr] <= w_r_corr;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_Q     = r_q_mem[r_rd_ptr];
   assign bus.out_R     = r_r_mem[r_rd_ptr];
   assign bus.count     = r_count;
endmodule

// File: tb/tb_nrd_result_fifo.sv
// Scoreboard bench for nrd_result_fifo (WIDTH=4, DEPTH=4): directed pushes
// queue their hand-computed results; a negedge monitor compares every pop.
module tb_nrd_result_fifo;
   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
`ifdef NRD_DBZ_DETECT_EN
   localparam logic DBZ_EXP = 1'b1;
`else
   localparam logic DBZ_EXP = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] q;
      logic [3:0] r;
      logic       dbz;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t sb_q[$];
   exp_t cur_exp;
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   nrd_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   nrd_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor compares the head on each pop, then records each accepted push.
   always @(negedge clk) begin
      if (rst !== 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got Q=%0h R=%0h with nothing expected at %0t",
                     bus.out_Q, bus.out_R, $time);
         end else begin
            mon_e = sb_q.pop_front();
            check("sb_Q",   32'(bus.out_Q),   32'(mon_e.q));
            check("sb_R",   32'(bus.out_R),   32'(mon_e.r));
            check("sb_dbz", 32'(bus.out_dbz), 32'(mon_e.dbz));
         end
      end
      if (rst !== 1'b1 && bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
         sb_q.push_back(cur_exp);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] q, input logic [4:0] a, input logic [3:0] d1,
                        input logic [3:0] d2, input logic [3:0] eq, input logic [3:0] er,
                        input logic ed);
      bus.in_valid = 1'b1;
      bus.in_Q     = q;
      bus.in_A     = a;
      bus.in_D1    = d1;
      bus.in_D2    = d2;
      cur_exp      = '{q: eq, r: er, dbz: ed};
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   // Fill vectors: Q, A, D2, expected R (hand-computed).
   logic [3:0] fill_q  [5] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd7};
   logic [4:0] fill_a  [5] = '{5'b00011, 5'b11111, 5'b11100, 5'b00000, 5'b00010};
   logic [3:0] fill_d2 [5] = '{4'd5, 4'd5, 4'd6, 4'd9, 4'd4};
   logic [3:0] fill_r  [5] = '{4'd3, 4'd4, 4'd2, 4'd0, 4'd2};

   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_Q      = '0;
      bus.in_A      = '0;
      bus.in_D1     = '0;
      bus.in_D2     = '0;
      cur_exp       = '0;

      // Reset state
      #2;
      check("rst_count",     32'(bus.count),     0);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_in_ready",  32'(bus.in_ready),  0);
      check("rst_out_Q",     32'(bus.out_Q),     0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_in_ready", 32'(bus.in_ready), 1);
      tick();

      // Positive remainder: Q=4, A=1, D2=3 -> R=1, visible after one edge
      drive(4'd4, 5'b00001, 4'd0, 4'd3, 4'd4, 4'd1, 1'b0);
      tick();
      idle();
      check("pos_count",     32'(bus.count),     1);
      check("pos_out_valid", 32'(bus.out_valid), 1);
      check("pos_out_Q",     32'(bus.out_Q),     4);
      check("pos_out_R",     32'(bus.out_R),     1);
      check("pos_out_dbz",   32'(bus.out_dbz),   0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("pos_drain_count", 32'(bus.count), 0);

      // Negative remainder: A=-2, D2=3 -> R=1
      drive(4'd2, 5'b11110, 4'd0, 4'd3, 4'd2, 4'd1, 1'b0);
      tick();
      idle();
      check("neg_out_Q", 32'(bus.out_Q), 2);
      check("neg_out_R", 32'(bus.out_R), 1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("neg_drain_count", 32'(bus.count), 0);

      // Fill and backpressure: 5 pushes, only 4 accepted
      for (int i = 0; i < 5; i++) begin
         drive(fill_q[i], fill_a[i], 4'd0, fill_d2[i], fill_q[i], fill_r[i], 1'b0);
         if (i == 4)
            check("full_in_ready", 32'(bus.in_ready), 0);
         tick();
      end
      idle();
      check("full_count",     32'(bus.count),    4);
      check("full_in_ready2", 32'(bus.in_ready), 0);
      bus.out_ready = 1'b1;
      repeat (4) tick();
      bus.out_ready = 1'b0;
      check("fill_drain_count", 32'(bus.count), 0);
      check("fill_sb_empty",    sb_q.size(),    0);

      // Wrap and concurrency: count held at 2 for 10 push+pop cycles
      drive(4'hA, 5'b00011, 4'd0, 4'd7, 4'hA, 4'd3, 1'b0);
      tick();
      drive(4'hB, 5'b11101, 4'd0, 4'd6, 4'hB, 4'd3, 1'b0);
      tick();
      check("wrap_pre_count", 32'(bus.count), 2);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 1)
            drive(4'(i), 5'b11111, 4'd0, 4'(i), 4'(i), 4'(i - 1), 1'b0);
         else
            drive(4'(i), 5'(i), 4'd0, 4'd15, 4'(i), 4'(i), 1'b0);
         tick();
         check("wrap_count", 32'(bus.count), 2);
      end
      idle();
      repeat (2) tick();
      bus.out_ready = 1'b0;
      check("wrap_drain_count", 32'(bus.count), 0);

      // Asynchronous reset mid-stream with three entries held
      for (int i = 1; i <= 3; i++) begin
         drive(4'(i), 5'(i), 4'd0, 4'd15, 4'(i), 4'(i), 1'b0);
         tick();
      end
      idle();
      check("arst_pre_count", 32'(bus.count), 3);
      #2;
      rst = 1'b1;
      sb_q.delete();
      #1;
      check("arst_count",     32'(bus.count),     0);
      check("arst_out_valid", 32'(bus.out_valid), 0);
      check("arst_out_Q",     32'(bus.out_Q),     0);
      check("arst_out_R",     32'(bus.out_R),     0);
      check("arst_out_dbz",   32'(bus.out_dbz),   0);
      check("arst_in_ready",  32'(bus.in_ready),  0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      check("arst_post_valid", 32'(bus.out_valid), 0);
      check("arst_post_count", 32'(bus.count),     0);
      check("arst_post_ready", 32'(bus.in_ready),  1);
      bus.out_ready = 1'b0;

      // Divide-by-zero: D1=9, D2=0, Q=F, A=9
      drive(4'hF, 5'b01001, 4'd9, 4'd0, 4'hF, 4'd9, DBZ_EXP);
      tick();
      idle();
      check("dbz_out_Q",   32'(bus.out_Q),   32'hF);
      check("dbz_out_R",   32'(bus.out_R),   9);
      check("dbz_out_dbz", 32'(bus.out_dbz), 32'(DBZ_EXP));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("end_count",    32'(bus.count), 0);
      check("end_sb_empty", sb_q.size(),    0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
